// File: rtl/tx_current_reg_mc.sv
// Multi-channel TX current regulator: per-channel error/enable FSM plus one shared serial divider that sweeps channels on syncpulse.
// Optional TX_SLEW_LIMIT_EN bounds each period update to +/-SLEW_STEP from the previous value.
module tx_current_reg_mc #(
  parameter int W         = 16,
  parameter int NUM_CH    = 2,
  parameter int KW        = W + 4,
  parameter int SHIFT     = 3,
  parameter int SLEW_STEP = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   tx_mode,
  input  logic                syncpulse,
  input  logic [NUM_CH*W-1:0] i_fid,
  input  logic [NUM_CH*W-1:0] i_set,
  input  logic [W-1:0]        dz_tx,
  input  logic [W-1:0]        gate,
  input  logic [W-1:0]        f1,
  input  logic [W-1:0]        f2,
  input  logic [W-1:0]        l,
  input  logic [KW-1:0]       k_tx,
  output logic [NUM_CH-1:0]   drv_en,
  output logic [NUM_CH-1:0]   dir,
  output logic [NUM_CH*W-1:0] period,
  output logic [NUM_CH-1:0]   period_valid,
  output logic                busy,
  output logic                overrun
);
  localparam int NW  = KW + W;
  localparam int CW  = $clog2(NW + 1);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {CH_IDLE, CH_TRACK, CH_HOLD} ch_st_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE} sw_st_t;

  logic [W-1:0]      w_fid [NUM_CH];
  logic [W-1:0]      w_set [NUM_CH];
  logic [W-1:0]      r_d   [NUM_CH];
  logic [NUM_CH-1:0] r_dir;
  ch_st_t            r_st     [NUM_CH];
  ch_st_t            w_st_nxt [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign w_fid[c] = i_fid[c*W +: W];
    assign w_set[c] = i_set[c*W +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) r_d[c] <= '0;
      r_dir <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_d[c]   <= (w_fid[c] >= w_set[c]) ? w_fid[c] - w_set[c] : w_set[c] - w_fid[c];
        r_dir[c] <= w_fid[c] < w_set[c];
      end
    end
  end

  assign dir = r_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) r_st[c] <= CH_IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) r_st[c] <= w_st_nxt[c];
    end
  end

  // Dropping tx_mode wins over every other transition.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_st_nxt[c] = r_st[c];
      if (!tx_mode[c]) begin
        w_st_nxt[c] = CH_IDLE;
      end else begin
        case (r_st[c])
          CH_IDLE:  w_st_nxt[c] = CH_TRACK;
          CH_TRACK: if (r_d[c] == '0) w_st_nxt[c] = CH_HOLD;
          CH_HOLD:  if (r_d[c] >= dz_tx) w_st_nxt[c] = CH_TRACK;
          default:  w_st_nxt[c] = CH_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) drv_en[c] = (r_st[c] == CH_TRACK);
  end

  sw_st_t            r_sw, w_sw_nxt;
  logic [CHW-1:0]    r_ch;
  logic [W-1:0]      r_snap_d [NUM_CH];
  logic [NUM_CH-1:0] r_snap_act;
  logic [W-1:0]      r_dz, r_gate, r_f1, r_f2, r_l;
  logic [KW-1:0]     r_k;
  logic [NW-1:0]     r_num;
  logic [W-1:0]      r_rem;
  logic [CW-1:0]     r_cnt;
  logic              r_sel_f2;
  logic [NUM_CH*W-1:0] r_period;
  logic [NUM_CH-1:0] r_pvld;
  logic              r_ovr;

  logic [W-1:0]  w_cd, w_dd, w_rem_nxt, w_target, w_new;
  logic          w_skip, w_sat, w_last, w_qbit, w_adv;
  logic [NW-1:0] w_prod;
  logic [W:0]    w_trial;
  logic [NW:0]   w_n, w_sh;

  assign w_cd   = r_snap_d[r_ch];
  assign w_skip = !r_snap_act[r_ch] || (w_cd < r_dz);
  assign w_sat  = w_cd >= r_gate;
  assign w_last = (r_ch == CHW'(NUM_CH - 1));
  assign w_dd   = w_cd - r_dz;
  assign w_prod = NW'(r_k) * NW'(w_dd);

  // r_num shifts the dividend out of its top while quotient bits enter at the bottom.
  assign w_trial   = {r_rem, r_num[NW-1]};
  assign w_qbit    = w_trial >= {1'b0, r_l};
  assign w_rem_nxt = w_trial[W-1:0] - r_l;

  assign w_n      = r_sel_f2 ? (NW+1)'(r_f2) : (NW+1)'(r_num) + (NW+1)'(r_f1);
  assign w_sh     = w_n >> SHIFT;
  assign w_target = (|w_sh[NW:W]) ? '1 : w_sh[W-1:0];

`ifdef TX_SLEW_LIMIT_EN
  logic [NUM_CH-1:0] r_seen;
  logic [W-1:0]      w_prev;
  assign w_prev = r_period[r_ch*W +: W];
  always_comb begin
    w_new = w_target;
    if (r_seen[r_ch]) begin
      if (w_target > w_prev && (w_target - w_prev) > W'(SLEW_STEP))
        w_new = w_prev + W'(SLEW_STEP);
      else if (w_prev > w_target && (w_prev - w_target) > W'(SLEW_STEP))
        w_new = w_prev - W'(SLEW_STEP);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_seen <= '0;
    else if (r_sw == S_WRITE) r_seen[r_ch] <= 1'b1;
  end
`else
  assign w_new = w_target;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sw <= S_IDLE;
    else     r_sw <= w_sw_nxt;
  end

  always_comb begin
    w_sw_nxt = r_sw;
    case (r_sw)
      S_IDLE:  if (syncpulse) w_sw_nxt = S_LOAD;
      S_LOAD: begin
        if (w_skip)                     w_sw_nxt = w_last ? S_IDLE : S_LOAD;
        else if (w_sat || r_l == '0)    w_sw_nxt = S_WRITE;
        else                            w_sw_nxt = S_DIV;
      end
      S_DIV:   if (r_cnt == CW'(NW - 1)) w_sw_nxt = S_WRITE;
      S_WRITE: w_sw_nxt = w_last ? S_IDLE : S_LOAD;
      default: w_sw_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_sw != S_IDLE);
    w_adv = (r_sw == S_LOAD && w_skip) || (r_sw == S_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch       <= '0;
      for (int c = 0; c < NUM_CH; c++) r_snap_d[c] <= '0;
      r_snap_act <= '0;
      r_dz       <= '0;
      r_gate     <= '0;
      r_f1       <= '0;
      r_f2       <= '0;
      r_l        <= '0;
      r_k        <= '0;
      r_num      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_sel_f2   <= 1'b0;
      r_period   <= '0;
      r_pvld     <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_pvld <= '0;
      r_ovr  <= syncpulse && busy;
      case (r_sw)
        S_IDLE: begin
          if (syncpulse) begin
            for (int c = 0; c < NUM_CH; c++) begin
              r_snap_d[c]   <= r_d[c];
              r_snap_act[c] <= (r_st[c] != CH_IDLE);
            end
            r_dz   <= dz_tx;
            r_gate <= gate;
            r_f1   <= f1;
            r_f2   <= f2;
            r_l    <= l;
            r_k    <= k_tx;
            r_ch   <= '0;
          end
        end
        S_LOAD: begin
          if (!w_skip) begin
            r_sel_f2 <= w_sat;
            r_num    <= (r_l == '0) ? '1 : w_prod;
            r_rem    <= '0;
            r_cnt    <= '0;
          end
        end
        S_DIV: begin
          r_num <= {r_num[NW-2:0], w_qbit};
          r_rem <= w_qbit ? w_rem_nxt : w_trial[W-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_WRITE: begin
          r_period[r_ch*W +: W] <= w_new;
          r_pvld[r_ch]          <= 1'b1;
        end
        default: ;
      endcase
      if (w_adv && !w_last) r_ch <= r_ch + 1'b1;
    end
  end

  assign period       = r_period;
  assign period_valid = r_pvld;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_tx_current_reg_mc.sv
// Bench for tx_current_reg_mc: a reference model predicts each period strobe (channel, value, cycle)
// into a scoreboard queue; a monitor matches strobes as the DUT presents them.
module tb_tx_current_reg_mc;
  localparam int W   = 16;
  localparam int NCH = 2;
  localparam int KW  = 20;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]   tx_mode;
  logic             syncpulse;
  logic [NCH*W-1:0] i_fid, i_set;
  logic [W-1:0]     dz_tx, gate, f1, f2, l;
  logic [KW-1:0]    k_tx;
  logic [NCH-1:0]   drv_en, dir, period_valid;
  logic [NCH*W-1:0] period;
  logic             busy, overrun;

  tx_current_reg_mc #(.W(W), .NUM_CH(NCH), .KW(KW)) dut (
    .clk(clk), .rst(rst), .tx_mode(tx_mode), .syncpulse(syncpulse),
    .i_fid(i_fid), .i_set(i_set), .dz_tx(dz_tx), .gate(gate), .f1(f1), .f2(f2),
    .l(l), .k_tx(k_tx), .drv_en(drv_en), .dir(dir), .period(period),
    .period_valid(period_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; logic [W-1:0] p; int at; } exp_t;
  exp_t sb[$];
  logic [W-1:0] mp [NCH];
  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (overrun === 1'b1) ovr_cnt++;
    for (int c = 0; c < NCH; c++) begin
      if (period_valid[c] === 1'b1) begin
        if (sb.size() == 0) begin
          check("strobe_unexpected", period_valid[c], 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_ch", c, e.ch);
          check("strobe_period", period[c*W +: W], e.p);
          check("strobe_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic set_ch(input int c, input int fv, input int sv);
    i_fid[c*W +: W] = W'(fv);
    i_set[c*W +: W] = W'(sv);
  endtask

  function automatic logic [W-1:0] model_p(input longint d);
    longint n, p;
    if (d >= longint'(gate))   n = longint'(f2);
    else if (l == 0)           n = (longint'(1) << (KW + W)) - 1 + longint'(f1);
    else                       n = (longint'(k_tx) * (d - longint'(dz_tx))) / longint'(l) + longint'(f1);
    p = n >> 3;
    if (p > 65535) p = 65535;
    return W'(p);
  endfunction

  // Channel cost: skipped 1 cycle, f2/saturated 2 cycles, divided KW+W+2 cycles.
  task automatic run_sweep(input int ovr_at);
    int e0, t, ovr0;
    longint d, fv, sv;
    @(negedge clk);
    e0 = cyc + 1;
    t = e0;
    for (int c = 0; c < NCH; c++) begin
      fv = longint'(i_fid[c*W +: W]);
      sv = longint'(i_set[c*W +: W]);
      d  = (fv >= sv) ? fv - sv : sv - fv;
      if (!tx_mode[c] || d < longint'(dz_tx)) begin
        t += 1;
      end else begin
        t += (d >= longint'(gate) || l == 0) ? 2 : KW + W + 2;
        mp[c] = model_p(d);
        sb.push_back('{c, mp[c], t});
      end
    end
    ovr0 = ovr_cnt;
    syncpulse = 1'b1;
    @(negedge clk);
    syncpulse = 1'b0;
    while (cyc < t - 1) begin
      syncpulse = (ovr_at > 0 && cyc + 1 == e0 + ovr_at);
      @(negedge clk);
    end
    syncpulse = 1'b0;
    check("busy_during", busy, 1);
    @(negedge clk);
    check("busy_after", busy, 0);
    @(negedge clk);
    check("overrun_count", ovr_cnt - ovr0, (ovr_at > 0) ? 1 : 0);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    for (int c = 0; c < NCH; c++) begin
      check("period_now", period[c*W +: W], mp[c]);
      check("dir", dir[c], i_fid[c*W +: W] < i_set[c*W +: W]);
    end
  endtask

  task automatic basic_cfg();
    dz_tx = 10; gate = 500; f1 = 100; f2 = 8000; k_tx = 64; l = 4;
    set_ch(0, 900, 1000);
    set_ch(1, 600, 0);
  endtask

  initial begin
    int fv, sv, off;
    rst = 1'b1; tx_mode = '0; syncpulse = 1'b0; i_fid = '0; i_set = '0;
    basic_cfg();
    for (int c = 0; c < NCH; c++) mp[c] = '0;
    repeat (3) @(negedge clk);
    check("rst_drv_en", drv_en, 0);
    check("rst_dir", dir, 0);
    check("rst_period", period, 0);
    check("rst_pvld", period_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // Basic sweep
    tx_mode = 2'b11;
    repeat (4) @(negedge clk);
    check("drv_en_on", drv_en, 2'b11);
    run_sweep(0);
    check("basic_ch0", period[15:0], 192);
    check("basic_ch1", period[31:16], 1000);

    // Deadzone skip keeps the old period
    set_ch(0, 995, 1000);
    repeat (3) @(negedge clk);
    run_sweep(0);
    check("dz_hold_ch0", period[15:0], 192);

    // Overrun mid-sweep leaves the sweep untouched
    set_ch(0, 900, 1000);
    repeat (3) @(negedge clk);
    run_sweep(5);
    check("ovr_ch0", period[15:0], 192);
    check("ovr_ch1", period[31:16], 1000);

    // Channel FSM
    tx_mode[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("fsm_idle", drv_en[0], 0);
    tx_mode[0] = 1'b1;
    @(negedge clk);
    check("fsm_track", drv_en[0], 1);
    set_ch(0, 1000, 1000);
    repeat (2) @(negedge clk);
    check("fsm_hold", drv_en[0], 0);
    set_ch(0, 991, 1000);
    repeat (4) @(negedge clk);
    check("fsm_d9", drv_en[0], 0);
    set_ch(0, 990, 1000);
    repeat (2) @(negedge clk);
    check("fsm_d10", drv_en[0], 1);
    set_ch(0, 1000, 1000);
    repeat (2) @(negedge clk);
    check("fsm_hold2", drv_en[0], 0);
    tx_mode[0] = 1'b0;
    @(negedge clk);
    set_ch(0, 900, 1000);
    repeat (3) @(negedge clk);
    check("fsm_off_idle", drv_en[0], 0);
    tx_mode[0] = 1'b1;
    @(negedge clk);
    check("fsm_reenter", drv_en[0], 1);

    // l == 0 saturation
    l = 0;
    repeat (2) @(negedge clk);
    run_sweep(0);
    check("sat_ch0", period[15:0], 65535);

    // Reset mid-divide
    basic_cfg();
    repeat (2) @(negedge clk);
    syncpulse = 1'b1;
    @(negedge clk);
    syncpulse = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_period", period, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drv_en", drv_en, 0);
    check("mid_rst_dir", dir, 0);
    check("mid_rst_pvld", period_valid, 0);
    sb.delete();
    for (int c = 0; c < NCH; c++) mp[c] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_sweep(0);
    check("post_rst_ch0", period[15:0], 192);
    check("post_rst_ch1", period[31:16], 1000);

    // Randomized sweeps
    for (int it = 0; it < 30; it++) begin
      dz_tx = W'($urandom_range(0, 200));
      gate  = W'($urandom_range(0, 3000));
      f1    = W'($urandom_range(0, 65535));
      f2    = W'($urandom_range(0, 65535));
      k_tx  = KW'($urandom_range(0, (1 << KW) - 1));
      l     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 400));
      for (int c = 0; c < NCH; c++) begin
        sv  = int'($urandom_range(0, 65535));
        off = int'($urandom_range(0, 3000));
        if ($urandom_range(0, 1) == 1) fv = (sv + off > 65535) ? 65535 : sv + off;
        else                           fv = (sv > off) ? sv - off : 0;
        set_ch(c, fv, sv);
      end
      tx_mode = NCH'($urandom_range(0, (1 << NCH) - 1));
      repeat (4) @(negedge clk);
      run_sweep((it % 5 == 2) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
